// File: rtl/pkt_stream_pkg.sv
// Shared constants, types and sizing helpers for the packet stream buffer.
package pkt_stream_pkg;

   localparam int MODE_CUT_THROUGH = 0;
   localparam int MODE_STORE_FWD   = 1;

   // Framing tracker: outside a packet, or between a start beat and its last beat.
   typedef enum logic {
      FR_IDLE   = 1'b0,
      FR_IN_PKT = 1'b1
   } frame_state_e;

   // Address width for a DEPTH-entry store (never narrower than one bit).
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One stored entry is {head, data, start, last}.
   function automatic int entry_width(input int head_w, input int data_w);
      return head_w + data_w + 2;
   endfunction

endpackage

// File: rtl/pkt_stream_ram.sv
// Simple dual-port entry store: synchronous write, registered read.
module pkt_stream_ram
   import pkt_stream_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          wr_en,
   input  logic [addr_width(DEPTH)-1:0]  wr_addr,
   input  logic [WIDTH-1:0]              wr_data,
   input  logic [addr_width(DEPTH)-1:0]  rd_addr,
   output logic [WIDTH-1:0]              rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Write port and registered read port; a same-address read returns the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/pkt_stream_buffer.sv
// Elastic FWFT buffer for the header/data packet stream with optional
// store-and-forward release, occupancy output and framing/oversize errors.
module pkt_stream_buffer
   import pkt_stream_pkg::*;
#(
   parameter int HEADER_BUS_WIDTH  = 512,
   parameter int PAYLOAD_BUS_WIDTH = 512,
   parameter int DEPTH             = 16,
   parameter int MODE              = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_packet_in_valid,
   input  logic [HEADER_BUS_WIDTH-1:0]   iv_packet_in_head,
   input  logic [PAYLOAD_BUS_WIDTH-1:0]  iv_packet_in_data,
   input  logic                          i_packet_in_start,
   input  logic                          i_packet_in_last,
   output logic                          o_packet_in_ready,
   output logic                          o_packet_out_valid,
   output logic [HEADER_BUS_WIDTH-1:0]   ov_packet_out_head,
   output logic [PAYLOAD_BUS_WIDTH-1:0]  ov_packet_out_data,
   output logic                          o_packet_out_start,
   output logic                          o_packet_out_last,
   input  logic                          i_packet_out_ready,
   output logic [addr_width(DEPTH):0]    ov_occupancy,
   output logic                          o_framing_err,
   output logic                          o_oversize_err
);

   localparam int AW = addr_width(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = entry_width(HEADER_BUS_WIDTH, PAYLOAD_BUS_WIDTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d, commit_q, commit_d;
   logic          force_q, force_d, oversize_q, oversize_d;
   logic          bypass_q, bypass_d;
   logic [EW-1:0] byp_q, byp_d;
   frame_state_e  frame_q, frame_d;
   logic          frame_err_q, frame_err_d;

   logic [EW-1:0] wr_entry, ram_rd_data, head_entry;
   logic          in_ready, wr_fire, rd_fire, out_valid, release_ok, head_last;

   assign in_ready   = (count_q < CW'(DEPTH));
   assign wr_fire    = i_packet_in_valid && in_ready;
   assign wr_entry   = {iv_packet_in_head, iv_packet_in_data, i_packet_in_start, i_packet_in_last};
   // A beat written straight into the head slot is not yet visible through
   // the registered RAM read, so it is served from the bypass copy for one cycle.
   assign head_entry = bypass_q ? byp_q : ram_rd_data;
   assign head_last  = head_entry[0];
   assign release_ok = (MODE == MODE_CUT_THROUGH) || (commit_q != '0) || force_q;
   assign out_valid  = (count_q != '0) && release_ok;
   assign rd_fire    = out_valid && i_packet_out_ready;

   pkt_stream_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr_d),
      .rd_data (ram_rd_data)
   );

   // Pointers, occupancy and head-slot bypass; the RAM prefetches the next head address.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      bypass_d = 1'b0;
      byp_d    = byp_q;
      if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (wr_fire && (wr_ptr_q == rd_ptr_d)) begin
         bypass_d = 1'b1;
         byp_d    = wr_entry;
      end
   end

   // Committed-packet count and forced release of a partial packet that fills the buffer.
   always_comb begin
      commit_d   = commit_q;
      force_d    = force_q;
      oversize_d = oversize_q;
      if (MODE == MODE_STORE_FWD) begin
         case ({wr_fire && i_packet_in_last, rd_fire && head_last})
            2'b10:   commit_d = commit_q + CW'(1);
            2'b01:   commit_d = commit_q - CW'(1);
            default: commit_d = commit_q;
         endcase
         if (rd_fire && head_last) force_d = 1'b0;
         if ((count_q == CW'(DEPTH)) && (commit_q == '0)) begin
            force_d    = 1'b1;
            oversize_d = 1'b1;
         end
      end
   end

   // Framing tracker next state.
   always_comb begin
      frame_d = frame_q;
      if (wr_fire) begin
         if (i_packet_in_start && !i_packet_in_last) frame_d = FR_IN_PKT;
         else if (i_packet_in_last)                  frame_d = FR_IDLE;
      end
   end

   // Framing violation: a start inside a packet, or a continuation outside one.
   always_comb begin
      frame_err_d = 1'b0;
      if (wr_fire) begin
         frame_err_d = i_packet_in_start ? (frame_q == FR_IN_PKT) : (frame_q == FR_IDLE);
      end
   end

   // Framing tracker state register.
   always_ff @(posedge clk) begin
      if (rst) frame_q <= FR_IDLE;
      else     frame_q <= frame_d;
   end

   // Datapath and control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         commit_q    <= '0;
         force_q     <= 1'b0;
         oversize_q  <= 1'b0;
         bypass_q    <= 1'b0;
         byp_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         commit_q    <= commit_d;
         force_q     <= force_d;
         oversize_q  <= oversize_d;
         bypass_q    <= bypass_d;
         byp_q       <= byp_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Output fields read as zero whenever no beat is being presented.
   assign o_packet_in_ready  = in_ready;
   assign o_packet_out_valid = out_valid;
   assign ov_packet_out_head = out_valid ? head_entry[EW-1 -: HEADER_BUS_WIDTH] : '0;
   assign ov_packet_out_data = out_valid ? head_entry[PAYLOAD_BUS_WIDTH+1:2] : '0;
   assign o_packet_out_start = out_valid && head_entry[1];
   assign o_packet_out_last  = out_valid && head_entry[0];
   assign ov_occupancy       = count_q;
   assign o_framing_err      = frame_err_q;
   assign o_oversize_err     = oversize_q;

endmodule

// File: tb/tb_pkt_stream_buffer.sv
// Bench: three buffers (cut-through D=4, store-and-forward D=8, store-and-forward D=4)
// checked against a per-instance scoreboard of expected beats.
module tb_pkt_stream_buffer;

   localparam int N = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid [N];
   logic       in_start [N];
   logic       in_last  [N];
   logic       in_ready [N];
   logic [7:0] in_head  [N];
   logic [7:0] in_data  [N];
   logic       out_valid[N];
   logic       out_start[N];
   logic       out_last [N];
   logic       out_ready[N];
   logic [7:0] out_head [N];
   logic [7:0] out_data [N];
   logic [3:0] occ      [N];
   logic       fr_err   [N];
   logic       ov_err   [N];

   int n_checks = 0;
   int n_fail   = 0;
   int pops     [N];
   int fr_cnt   [N];
   int occ_max  [N];

   logic [17:0] sb0[$];
   logic [17:0] sb1[$];
   logic [17:0] sb2[$];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int DEP = (gi == 1) ? 8 : 4;
      localparam int MD  = (gi == 0) ? 0 : 1;
      logic [$clog2(DEP):0] occ_w;
      pkt_stream_buffer #(
         .HEADER_BUS_WIDTH  (8),
         .PAYLOAD_BUS_WIDTH (8),
         .DEPTH             (DEP),
         .MODE              (MD)
      ) u_dut (
         .clk                (clk),
         .rst                (rst),
         .i_packet_in_valid  (in_valid[gi]),
         .iv_packet_in_head  (in_head[gi]),
         .iv_packet_in_data  (in_data[gi]),
         .i_packet_in_start  (in_start[gi]),
         .i_packet_in_last   (in_last[gi]),
         .o_packet_in_ready  (in_ready[gi]),
         .o_packet_out_valid (out_valid[gi]),
         .ov_packet_out_head (out_head[gi]),
         .ov_packet_out_data (out_data[gi]),
         .o_packet_out_start (out_start[gi]),
         .o_packet_out_last  (out_last[gi]),
         .i_packet_out_ready (out_ready[gi]),
         .ov_occupancy       (occ_w),
         .o_framing_err      (fr_err[gi]),
         .o_oversize_err     (ov_err[gi])
      );
      assign occ[gi] = 4'(occ_w);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic void sb_push(input int d, input logic [17:0] v);
      case (d)
         0:       sb0.push_back(v);
         1:       sb1.push_back(v);
         default: sb2.push_back(v);
      endcase
   endfunction

   function automatic int sb_size(input int d);
      case (d)
         0:       return sb0.size();
         1:       return sb1.size();
         default: return sb2.size();
      endcase
   endfunction

   function automatic logic [17:0] sb_pop(input int d);
      case (d)
         0:       return sb0.pop_front();
         1:       return sb1.pop_front();
         default: return sb2.pop_front();
      endcase
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offers one beat (entered and left at posedge+1); the expected beat is queued when accepted.
   task automatic send(input int d, input logic [7:0] dat, input logic s, input logic l);
      int t = 0;
      in_valid[d] = 1'b1;
      in_data[d]  = dat;
      in_head[d]  = dat ^ 8'hA5;
      in_start[d] = s;
      in_last[d]  = l;
      while (!in_ready[d] && t < 100) begin
         cyc(1);
         t++;
      end
      if (t >= 100) check($sformatf("send_timeout%0d", d), 32'(in_ready[d]), 32'd1);
      else          sb_push(d, {dat ^ 8'hA5, dat, s, l});
      cyc(1);
      in_valid[d] = 1'b0;
      in_start[d] = 1'b0;
      in_last[d]  = 1'b0;
   endtask

   // Output monitor: each consumed beat is compared against the scoreboard head.
   always @(negedge clk) begin
      for (int d = 0; d < N; d++) begin
         if (!rst) begin
            if (fr_err[d]) fr_cnt[d]++;
            if (int'(occ[d]) > occ_max[d]) occ_max[d] = int'(occ[d]);
            if (out_valid[d] && out_ready[d]) begin
               pops[d]++;
               check($sformatf("sb_has_beat%0d", d), 32'(sb_size(d) != 0), 32'd1);
               if (sb_size(d) != 0)
                  check($sformatf("beat%0d", d),
                        32'({out_head[d], out_data[d], out_start[d], out_last[d]}),
                        32'(sb_pop(d)));
            end
         end
      end
   end

   initial begin
      int p0;
      int f0;
      int t;
      for (int d = 0; d < N; d++) begin
         in_valid[d] = 0; in_start[d] = 0; in_last[d] = 0; out_ready[d] = 0;
         in_head[d] = 0; in_data[d] = 0;
         pops[d] = 0; fr_cnt[d] = 0; occ_max[d] = 0;
      end
      cyc(3);
      rst = 1'b0;

      // Reset state of every instance.
      for (int d = 0; d < N; d++) begin
         check($sformatf("rst_valid%0d", d), 32'(out_valid[d]), 32'd0);
         check($sformatf("rst_ready%0d", d), 32'(in_ready[d]), 32'd1);
         check($sformatf("rst_occ%0d", d), 32'(occ[d]), 32'd0);
         check($sformatf("rst_ferr%0d", d), 32'(fr_err[d]), 32'd0);
         check($sformatf("rst_oerr%0d", d), 32'(ov_err[d]), 32'd0);
         check($sformatf("rst_data%0d", d), 32'(out_data[d]), 32'd0);
         check($sformatf("rst_head%0d", d), 32'({out_head[d], out_start[d], out_last[d]}), 32'd0);
      end

      // Cut-through, 3-beat packet, downstream always ready.
      out_ready[0] = 1'b1;
      send(0, 8'h11, 1'b1, 1'b0);
      check("ct_latency", 32'(out_valid[0]), 32'd1);
      send(0, 8'h22, 1'b0, 1'b0);
      send(0, 8'h33, 1'b0, 1'b1);
      cyc(3);
      check("ct_occ_peak", 32'(occ_max[0]), 32'd1);
      check("ct_occ_drained", 32'(occ[0]), 32'd0);

      // Cut-through back-pressure: 4 beats fill the buffer, a 5th waits.
      out_ready[0] = 1'b0;
      send(0, 8'h41, 1'b1, 1'b0);
      send(0, 8'h42, 1'b0, 1'b0);
      send(0, 8'h43, 1'b0, 1'b0);
      send(0, 8'h44, 1'b0, 1'b0);
      check("ct_full_ready", 32'(in_ready[0]), 32'd0);
      check("ct_full_occ", 32'(occ[0]), 32'd4);
      cyc(1);
      check("ct_stall_hold", 32'(out_data[0]), 32'h41);
      fork
         send(0, 8'h45, 1'b0, 1'b1);
         begin
            cyc(2);
            out_ready[0] = 1'b1;
         end
      join
      cyc(6);
      check("ct_bp_drained", 32'(occ[0]), 32'd0);

      // Store-and-forward D=8: held until the last beat is written.
      out_ready[1] = 1'b1;
      send(1, 8'h61, 1'b1, 1'b0);
      send(1, 8'h62, 1'b0, 1'b0);
      send(1, 8'h63, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("sf_hold%0d", i), 32'(out_valid[1]), 32'd0);
         cyc(1);
      end
      send(1, 8'h64, 1'b0, 1'b1);
      check("sf_release", 32'(out_valid[1]), 32'd1);
      p0 = pops[1];
      cyc(4);
      check("sf_back_to_back", 32'(pops[1] - p0), 32'd4);
      check("sf_drained", 32'(occ[1]), 32'd0);

      // Store-and-forward D=4: 6-beat packet overflows and is force-released.
      out_ready[2] = 1'b1;
      send(2, 8'h81, 1'b1, 1'b0);
      send(2, 8'h82, 1'b0, 1'b0);
      send(2, 8'h83, 1'b0, 1'b0);
      check("ovf_before", 32'(ov_err[2]), 32'd0);
      send(2, 8'h84, 1'b0, 1'b0);
      check("ovf_full_ready", 32'(in_ready[2]), 32'd0);
      send(2, 8'h85, 1'b0, 1'b0);
      send(2, 8'h86, 1'b0, 1'b1);
      cyc(8);
      check("ovf_sticky", 32'(ov_err[2]), 32'd1);
      check("ovf_drained", 32'(occ[2]), 32'd0);

      // Framing: start, start, last -> one pulse on the second start.
      f0 = fr_cnt[0];
      send(0, 8'hA1, 1'b1, 1'b0);
      check("fr_first_start", 32'(fr_err[0]), 32'd0);
      send(0, 8'hA2, 1'b1, 1'b0);
      check("fr_second_start", 32'(fr_err[0]), 32'd1);
      send(0, 8'hA3, 1'b0, 1'b1);
      check("fr_last", 32'(fr_err[0]), 32'd0);
      cyc(3);
      check("fr_pulse_count", 32'(fr_cnt[0] - f0), 32'd1);

      // Reset with three beats stored.
      out_ready[0] = 1'b0;
      send(0, 8'hB1, 1'b1, 1'b0);
      send(0, 8'hB2, 1'b0, 1'b0);
      send(0, 8'hB3, 1'b0, 1'b0);
      check("mid_occ", 32'(occ[0]), 32'd3);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      sb0.delete();
      sb1.delete();
      sb2.delete();
      check("mrst_occ", 32'(occ[0]), 32'd0);
      check("mrst_valid", 32'(out_valid[0]), 32'd0);
      check("mrst_ready", 32'(in_ready[0]), 32'd1);
      check("mrst_data", 32'(out_data[0]), 32'd0);
      check("mrst_oerr", 32'(ov_err[2]), 32'd0);
      out_ready[0] = 1'b1;
      send(0, 8'hC1, 1'b1, 1'b0);
      send(0, 8'hC2, 1'b0, 1'b1);
      check("post_rst_ferr", 32'(fr_err[0]), 32'd0);

      // Drain and confirm every expected beat was produced.
      t = 0;
      while ((sb_size(0) + sb_size(1) + sb_size(2)) != 0 && t < 50) begin
         cyc(1);
         t++;
      end
      for (int d = 0; d < N; d++)
         check($sformatf("sb_empty%0d", d), 32'(sb_size(d)), 32'd0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
